// File: rtl/byte_packer_pkg.sv
// Shared constants and helpers for the byte-to-word packer.
package byte_packer_pkg;

   localparam int BYTE_W    = 8;
   localparam int LANES_DEF = 4;

   // Mask with bits [c:0] set; wide enough for the largest legal word (8 lanes).
   function automatic logic [7:0] keep_mask(input int c);
      logic [7:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) begin
         m[k] = (k <= c);
      end
      return m;
   endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out stream bundle for byte_packer.
interface byte_packer_if
   import byte_packer_pkg::*;
#(
   parameter int LANES = LANES_DEF
);
   logic                      i_valid_i;
   logic [BYTE_W-1:0]         i_data_i;
   logic                      i_last_i;
   logic                      i_ready_o;
   logic                      e_valid_o;
   logic [BYTE_W*LANES-1:0]   e_data_o;
   logic [LANES-1:0]          e_keep_o;
   logic                      e_last_o;
   logic                      e_ready_i;

   modport slave (
      input  i_valid_i, i_data_i, i_last_i, e_ready_i,
      output i_ready_o, e_valid_o, e_data_o, e_keep_o, e_last_o
   );

   modport master (
      output i_valid_i, i_data_i, i_last_i, e_ready_i,
      input  i_ready_o, e_valid_o, e_data_o, e_keep_o, e_last_o
   );
endinterface

// File: rtl/byte_packer_out_reg.sv
// Output holding register: loads a completed word and holds it until the consumer takes it.
module pack_out_reg
   import byte_packer_pkg::*;
#(
   parameter int LANES = LANES_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [BYTE_W*LANES-1:0] load_data,
   input  logic [LANES-1:0]        load_keep,
   input  logic                    load_last,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [BYTE_W*LANES-1:0] out_data,
   output logic [LANES-1:0]        out_keep,
   output logic                    out_last
);

   // A load in the same cycle as a transfer replaces the old word with no bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_keep  <= load_keep;
         out_last  <= load_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/byte_packer.sv
// Packs an 8-bit valid/ready byte stream little-endian into LANES-byte words with keep/last.
module byte_packer
   import byte_packer_pkg::*;
#(
   parameter int LANES = LANES_DEF
) (
   input  logic          clk,
   input  logic          reset,
   byte_packer_if.slave  bus
);

   localparam int CNT_W = (LANES > 2) ? $clog2(LANES) : 1;
   localparam int WORD_W = BYTE_W * LANES;

   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] merged;
   logic [LANES-1:0]  load_keep;
   logic              accept;
   logic              complete;

   logic              out_valid;
   logic [WORD_W-1:0] out_data;
   logic [LANES-1:0]  out_keep;
   logic              out_last;

   assign bus.i_ready_o = !reset && (!out_valid || bus.e_ready_i);
   assign accept        = bus.i_valid_i && bus.i_ready_o;
   assign complete      = accept && ((cnt == CNT_W'(LANES - 1)) || bus.i_last_i);
   assign load_keep     = LANES'(keep_mask(int'(cnt)));

   // Lanes above cnt are always zero in acc, so an early word is zero-padded for free.
   always_comb begin
      merged = acc;
      merged[BYTE_W*int'(cnt) +: BYTE_W] = bus.i_data_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         acc <= '0;
      end else if (complete) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         cnt <= cnt + CNT_W'(1);
         acc <= merged;
      end
   end

   pack_out_reg #(.LANES(LANES)) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (complete),
      .load_data (merged),
      .load_keep (load_keep),
      .load_last (bus.i_last_i),
      .out_ready (bus.e_ready_i),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last)
   );

   assign bus.e_valid_o = out_valid;
   assign bus.e_data_o  = out_data;
   assign bus.e_keep_o  = out_keep;
   assign bus.e_last_o  = out_last;

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer (LANES=4): vector table plus stall and reset sequences.
module tb_byte_packer;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   byte_packer_if #(.LANES(4)) bus ();

   byte_packer #(.LANES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        er;
      logic        x_rdy;
      logic        x_ev;
      logic [31:0] x_data;
      logic [3:0]  x_keep;
      logic        x_last;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic er);
      @(posedge clk);
      #1;
      bus.i_valid_i = v;
      bus.i_data_i  = d;
      bus.i_last_i  = l;
      bus.e_ready_i = er;
   endtask

   task automatic check_word(input string name, input logic [31:0] d, input logic [3:0] k,
                             input logic l);
      check({name, "_valid"}, 32'(bus.e_valid_o), 32'd1);
      check({name, "_data"},  bus.e_data_o, d);
      check({name, "_keep"},  32'(bus.e_keep_o), 32'(k));
      check({name, "_last"},  32'(bus.e_last_o), 32'(l));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      bus.i_valid_i = 1'b0;
      bus.i_data_i  = 8'h00;
      bus.i_last_i  = 1'b0;
      bus.e_ready_i = 1'b1;
      reset = 1'b1;

      //           v  d      l  er  rdy ev  data           keep  last
      vecs[0]  = '{1, 8'h11, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[1]  = '{1, 8'h22, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[2]  = '{1, 8'h33, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[3]  = '{1, 8'h44, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[4]  = '{1, 8'hAA, 0, 1,  1,  1,  32'h44332211,  4'hF, 0};
      vecs[5]  = '{1, 8'hBB, 1, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[6]  = '{1, 8'h5C, 1, 1,  1,  1,  32'h0000BBAA,  4'h3, 1};
      vecs[7]  = '{1, 8'h01, 0, 1,  1,  1,  32'h0000005C,  4'h1, 1};
      vecs[8]  = '{1, 8'h02, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[9]  = '{1, 8'h03, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[10] = '{1, 8'h04, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[11] = '{1, 8'h05, 0, 1,  1,  1,  32'h04030201,  4'hF, 0};
      vecs[12] = '{1, 8'h06, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[13] = '{1, 8'h07, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[14] = '{1, 8'h08, 0, 1,  1,  0,  32'h0,         4'h0, 0};
      vecs[15] = '{0, 8'h00, 0, 1,  1,  1,  32'h08070605,  4'hF, 0};
      vecs[16] = '{0, 8'h00, 0, 1,  1,  0,  32'h0,         4'h0, 0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(bus.i_ready_o), 32'd0);
      check("rst_valid", 32'(bus.e_valid_o), 32'd0);
      check("rst_data",  bus.e_data_o, 32'd0);
      check("rst_keep",  32'(bus.e_keep_o), 32'd0);
      check("rst_last",  32'(bus.e_last_o), 32'd0);
      reset = 1'b0;
      #1;
      check("rel_ready", 32'(bus.i_ready_o), 32'd1);

      // Table: full words, early last, single-byte frame, back-to-back words
      for (int r = 0; r < 17; r++) begin
         drive(vecs[r].v, vecs[r].d, vecs[r].l, vecs[r].er);
         @(negedge clk);
         check($sformatf("vec%0d_ready", r), 32'(bus.i_ready_o), 32'(vecs[r].x_rdy));
         check($sformatf("vec%0d_valid", r), 32'(bus.e_valid_o), 32'(vecs[r].x_ev));
         if (vecs[r].x_ev) begin
            check($sformatf("vec%0d_data", r), bus.e_data_o, vecs[r].x_data);
            check($sformatf("vec%0d_keep", r), 32'(bus.e_keep_o), 32'(vecs[r].x_keep));
            check($sformatf("vec%0d_last", r), 32'(bus.e_last_o), 32'(vecs[r].x_last));
         end
      end

      // Backpressure: word held stable, bytes refused, release restores ready at once
      drive(1, 8'h55, 0, 0);
      drive(1, 8'h66, 0, 0);
      drive(1, 8'h77, 0, 0);
      drive(1, 8'h88, 0, 0);
      @(negedge clk);
      check("stall_pre_ready", 32'(bus.i_ready_o), 32'd1);
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'h99, 0, 0);
         @(negedge clk);
         check($sformatf("stall%0d_ready", i), 32'(bus.i_ready_o), 32'd0);
         check_word($sformatf("stall%0d", i), 32'h88776655, 4'hF, 1'b0);
      end
      drive(0, 8'h00, 0, 1);
      @(negedge clk);
      check("release_ready", 32'(bus.i_ready_o), 32'd1);
      check("release_valid", 32'(bus.e_valid_o), 32'd1);
      drive(1, 8'hA0, 0, 1);
      @(negedge clk);
      check("post_xfer_valid", 32'(bus.e_valid_o), 32'd0);
      drive(1, 8'hA1, 0, 1);
      drive(1, 8'hA2, 0, 1);
      drive(1, 8'hA3, 0, 1);
      drive(0, 8'h00, 0, 1);
      @(negedge clk);
      check_word("after_stall", 32'hA3A2A1A0, 4'hF, 1'b0);

      // Reset mid-word discards the partial bytes
      drive(1, 8'h31, 0, 1);
      drive(1, 8'h32, 0, 1);
      drive(0, 8'h00, 0, 1);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_ready", 32'(bus.i_ready_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1, 8'h10, 0, 1);
      drive(1, 8'h11, 0, 1);
      drive(1, 8'h12, 0, 1);
      @(negedge clk);
      check("midrst_no_early", 32'(bus.e_valid_o), 32'd0);
      drive(1, 8'h13, 0, 1);
      drive(0, 8'h00, 0, 1);
      @(negedge clk);
      check_word("midrst_word", 32'h13121110, 4'hF, 1'b0);
      drive(0, 8'h00, 0, 1);
      @(negedge clk);
      check("midrst_single", 32'(bus.e_valid_o), 32'd0);

      // Reset drops a pending, stalled output word
      drive(1, 8'hE0, 0, 0);
      drive(1, 8'hE1, 0, 0);
      drive(1, 8'hE2, 0, 0);
      drive(1, 8'hE3, 0, 0);
      drive(0, 8'h00, 0, 0);
      @(negedge clk);
      check_word("pend_word", 32'hE3E2E1E0, 4'hF, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      check("pend_rst_valid", 32'(bus.e_valid_o), 32'd0);
      check("pend_rst_data",  bus.e_data_o, 32'd0);
      check("pend_rst_keep",  32'(bus.e_keep_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 8'h00, 0, 1);
      @(negedge clk);
      check("pend_after_valid", 32'(bus.e_valid_o), 32'd0);
      check("pend_after_ready", 32'(bus.i_ready_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
